// File: rtl/sram_1r1w_init_bypass_pkg.sv
// Shared types and elaboration helpers for the 1R1W SRAM model.
package sram_pkg;

  typedef enum logic [0:0] {StInit, StReady} sram_state_e;

  // Address width for a given depth. The result is at least 1, so a 2-entry table still gets a port.
  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) w++;
    return w;
  endfunction

  // Returns 1 when the geometry is usable: at least two entries and whole mask lanes.
  function automatic bit params_ok(input int unsigned depth, input int unsigned width,
                                   input int unsigned mask_gran);
    return (depth >= 2) && (mask_gran != 0) && ((width % mask_gran) == 0);
  endfunction

endpackage

// File: rtl/sram_1r1w_init_bypass_if.sv
// Read/write port bundle for the 1R1W SRAM. The master drives requests and the slave is the macro.
interface sram_1r1w_init_bypass_if #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MASK_SEGS = 1
);
  logic                 R0_en;
  logic [ADDR_W-1:0]    R0_addr;
  logic                 R0_valid;
  logic [WIDTH-1:0]     R0_data;
  logic                 W0_en;
  logic [ADDR_W-1:0]    W0_addr;
  logic [WIDTH-1:0]     W0_data;
  logic [MASK_SEGS-1:0] W0_mask;
  logic                 init_done;

  modport master (
    output R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
    input  R0_valid, R0_data, init_done
  );

  modport slave (
    input  R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
    output R0_valid, R0_data, init_done
  );
endinterface

// File: rtl/sram_masked_array.sv
// Pure storage: one lane-masked synchronous write port and a combinational read of the addressed
// entry. It has no reset; the owner clears it by sweeping zeros through the write port.
module sram_masked_array #(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MASK_GRAN = 7,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [ADDR_W-1:0]              waddr_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic [(WIDTH/MASK_GRAN)-1:0]   wmask_i,
  input  logic [ADDR_W-1:0]              raddr_i,
  output logic [WIDTH-1:0]               rdata_o
);
  localparam int unsigned MaskSegs = WIDTH / MASK_GRAN;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Update only the lanes whose mask bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < MaskSegs; i++) begin
        if (wmask_i[i]) begin
          mem_q[waddr_i][i*MASK_GRAN +: MASK_GRAN] <= wdata_i[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Out-of-range addresses are filtered by the owner, which discards this value for them.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sram_1r1w_init_bypass.sv
// Parametrised single-clock 1R1W SRAM with hardware zero-init after reset, per-lane write masks,
// optional same-cycle read-during-write bypass and a holding registered read port.
module sram_1r1w_init_bypass
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MASK_GRAN = 7,
  parameter bit          BYPASS    = 1'b0,
  parameter int unsigned ADDR_W    = addr_width(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  sram_1r1w_init_bypass_if.slave  bus
);
  localparam int unsigned MASK_SEGS = WIDTH / MASK_GRAN;
  // One extra bit so the range compare also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  if (!params_ok(DEPTH, WIDTH, MASK_GRAN)) begin : g_bad_params
    $fatal(1, "sram_1r1w_init_bypass: need DEPTH >= 2 and WIDTH a multiple of MASK_GRAN");
  end

  sram_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    init_cnt_q, init_cnt_d;
  logic                 r_valid_q, r_valid_d;
  logic [WIDTH-1:0]     r_data_q, r_data_d;

  logic                 arr_we;
  logic [ADDR_W-1:0]    arr_waddr;
  logic [WIDTH-1:0]     arr_wdata;
  logic [MASK_SEGS-1:0] arr_wmask;
  logic [WIDTH-1:0]     arr_rdata;
  logic [WIDTH-1:0]     merged;

  logic                 w_in_range;
  logic                 r_in_range;
  logic                 rdw_hit;

  assign w_in_range = {1'b0, bus.W0_addr} < DepthExt;
  assign r_in_range = {1'b0, bus.R0_addr} < DepthExt;
  assign rdw_hit    = bus.W0_en && w_in_range && (bus.W0_addr == bus.R0_addr);

  // State, sweep counter and read register; reset discards any pending read result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
    end
  end

  // FSM and write-port mux: the zero sweep owns the array in INIT, W0 owns it in READY.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    arr_we     = 1'b0;
    arr_waddr  = bus.W0_addr;
    arr_wdata  = bus.W0_data;
    arr_wmask  = bus.W0_mask;
    case (state_q)
      StInit: begin
        arr_we    = 1'b1;
        arr_waddr = init_cnt_q;
        arr_wdata = '0;
        arr_wmask = '1;
        if (init_cnt_q == LastAddr) begin
          state_d = StReady;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_W'(1);
        end
      end
      StReady: begin
        arr_we = bus.W0_en && w_in_range;
      end
    endcase
  end

  // Read path: optional lane merge with same-address write data, then load or hold the register.
  always_comb begin
    merged    = arr_rdata;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    for (int unsigned i = 0; i < MASK_SEGS; i++) begin
      if (BYPASS && rdw_hit && bus.W0_mask[i]) begin
        merged[i*MASK_GRAN +: MASK_GRAN] = bus.W0_data[i*MASK_GRAN +: MASK_GRAN];
      end
    end
    if ((state_q == StReady) && bus.R0_en) begin
      r_valid_d = 1'b1;
      r_data_d  = r_in_range ? merged : '0;
    end
  end

  sram_masked_array #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clk_i   (clock),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .wmask_i (arr_wmask),
    .raddr_i (bus.R0_addr),
    .rdata_o (arr_rdata)
  );

  assign bus.R0_valid  = r_valid_q;
  assign bus.R0_data   = r_data_q;
  assign bus.init_done = (state_q == StReady);

endmodule

// File: tb/tb_sram_1r1w_init_bypass.sv
// Self-checking bench: three instances (bypass, no bypass, odd depth) share one stimulus stream and
// are compared each cycle against a per-instance behavioural model, plus fixed directed values.
module tb_sram_1r1w_init_bypass;

  localparam int NInst = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        r_en = 1'b0;
  logic [6:0]  r_addr = '0;
  logic        w_en = 1'b0;
  logic [6:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic [1:0]  w_mask = '0;

  logic        obs_valid [NInst];
  logic [15:0] obs_data  [NInst];
  logic        obs_init  [NInst];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state per instance.
  int          m_depth [NInst] = '{128, 128, 100};
  bit          m_byp   [NInst] = '{1'b1, 1'b0, 1'b1};
  int          m_edges [NInst];
  logic [15:0] m_mem   [NInst][128];
  logic [15:0] m_rdata [NInst];
  logic        m_rvalid[NInst];

  always #5 clock = ~clock;

  sram_1r1w_init_bypass_if #(.ADDR_W(7), .WIDTH(16), .MASK_SEGS(2)) if_a ();
  sram_1r1w_init_bypass_if #(.ADDR_W(7), .WIDTH(16), .MASK_SEGS(2)) if_b ();
  sram_1r1w_init_bypass_if #(.ADDR_W(7), .WIDTH(16), .MASK_SEGS(2)) if_c ();

  sram_1r1w_init_bypass #(.DEPTH(128), .WIDTH(16), .MASK_GRAN(8), .BYPASS(1'b1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .bus(if_a));
  sram_1r1w_init_bypass #(.DEPTH(128), .WIDTH(16), .MASK_GRAN(8), .BYPASS(1'b0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .bus(if_b));
  sram_1r1w_init_bypass #(.DEPTH(100), .WIDTH(16), .MASK_GRAN(8), .BYPASS(1'b1)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .bus(if_c));

  assign if_a.R0_en = r_en;  assign if_a.R0_addr = r_addr;  assign if_a.W0_en = w_en;
  assign if_a.W0_addr = w_addr;  assign if_a.W0_data = w_data;  assign if_a.W0_mask = w_mask;
  assign if_b.R0_en = r_en;  assign if_b.R0_addr = r_addr;  assign if_b.W0_en = w_en;
  assign if_b.W0_addr = w_addr;  assign if_b.W0_data = w_data;  assign if_b.W0_mask = w_mask;
  assign if_c.R0_en = r_en;  assign if_c.R0_addr = r_addr;  assign if_c.W0_en = w_en;
  assign if_c.W0_addr = w_addr;  assign if_c.W0_data = w_data;  assign if_c.W0_mask = w_mask;

  assign obs_valid[0] = if_a.R0_valid;  assign obs_data[0] = if_a.R0_data;
  assign obs_init[0]  = if_a.init_done;
  assign obs_valid[1] = if_b.R0_valid;  assign obs_data[1] = if_b.R0_data;
  assign obs_init[1]  = if_b.init_done;
  assign obs_valid[2] = if_c.R0_valid;  assign obs_data[2] = if_c.R0_data;
  assign obs_init[2]  = if_c.init_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] mask);
    logic [15:0] r;
    r = old;
    if (mask[0]) r[7:0] = nw[7:0];
    if (mask[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NInst; k++) begin
      m_edges[k]  = 0;
      m_rdata[k]  = '0;
      m_rvalid[k] = 1'b0;
      for (int a = 0; a < 128; a++) m_mem[k][a] = '0;
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    logic [15:0] old;
    for (int k = 0; k < NInst; k++) begin
      if (m_edges[k] >= m_depth[k]) begin
        old = (int'(r_addr) < m_depth[k]) ? m_mem[k][r_addr] : 16'h0;
        if (r_en) begin
          m_rvalid[k] = 1'b1;
          if (int'(r_addr) >= m_depth[k]) m_rdata[k] = '0;
          else if (m_byp[k] && w_en && (w_addr == r_addr)) m_rdata[k] = merge(old, w_data, w_mask);
          else m_rdata[k] = old;
        end else begin
          m_rvalid[k] = 1'b0;
        end
        if (w_en && (int'(w_addr) < m_depth[k]))
          m_mem[k][w_addr] = merge(m_mem[k][w_addr], w_data, w_mask);
      end else begin
        m_rvalid[k] = 1'b0;
        m_edges[k]++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < NInst; k++) begin
      check($sformatf("%s_valid%0d", tag, k), {31'b0, obs_valid[k]}, {31'b0, m_rvalid[k]});
      check($sformatf("%s_data%0d", tag, k), {16'b0, obs_data[k]}, {16'b0, m_rdata[k]});
      check($sformatf("%s_init%0d", tag, k), {31'b0, obs_init[k]},
            {31'b0, (m_edges[k] >= m_depth[k])});
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all("step");
  endtask

  task automatic drive(input logic ren, input logic [6:0] ra, input logic wen, input logic [6:0] wa,
                       input logic [15:0] wd, input logic [1:0] wm);
    r_en = ren;  r_addr = ra;  w_en = wen;  w_addr = wa;  w_data = wd;  w_mask = wm;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 1'b0, 7'd0, 16'h0, 2'b00);
  endtask

  // Asynchronous reset taken between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NInst; k++) begin
      check($sformatf("%s_data%0d", tag, k), {16'b0, obs_data[k]}, 32'h0);
      check($sformatf("%s_valid%0d", tag, k), {31'b0, obs_valid[k]}, 32'h0);
      check($sformatf("%s_init%0d", tag, k), {31'b0, obs_init[k]}, 32'h0);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int rise [NInst];
  int exp_rise [NInst] = '{128, 128, 100};

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    async_reset("por");

    // Partial sweep, then reset at init_cnt == 50 to restart from entry 0.
    for (int n = 0; n < 50; n++) step();
    async_reset("mid_init");

    // Count edges to init_done; writes to addr 2 during INIT must be ignored.
    for (int k = 0; k < NInst; k++) rise[k] = 0;
    for (int n = 1; n <= 140; n++) begin
      if (n <= 90) drive(1'b0, 7'd0, 1'b1, 7'd2, 16'hFFFF, 2'b11);
      else idle();
      step();
      for (int k = 0; k < NInst; k++) if (rise[k] == 0 && obs_init[k]) rise[k] = n;
    end
    for (int k = 0; k < NInst; k++) check($sformatf("init_rise%0d", k), rise[k], exp_rise[k]);

    // Freshly initialised entries read as zero.
    for (int i = 0; i < 4; i++) begin
      logic [6:0] ra;
      ra = (i == 0) ? 7'd0 : (i == 1) ? 7'd64 : (i == 2) ? 7'd127 : 7'd2;
      drive(1'b1, ra, 1'b0, 7'd0, 16'h0, 2'b00);
      step();
      for (int k = 0; k < NInst; k++) begin
        check($sformatf("zero_rd%0d_%0d", ra, k), {16'b0, obs_data[k]}, 32'h0);
        check($sformatf("zero_vld%0d_%0d", ra, k), {31'b0, obs_valid[k]}, 32'h1);
      end
    end

    // Masked write merge.
    drive(1'b0, 7'd0, 1'b1, 7'd5, 16'hABCD, 2'b11);  step();
    drive(1'b0, 7'd0, 1'b1, 7'd5, 16'h1234, 2'b01);  step();
    drive(1'b1, 7'd5, 1'b0, 7'd0, 16'h0, 2'b00);     step();
    for (int k = 0; k < NInst; k++) check($sformatf("mask_merge%0d", k), obs_data[k], 32'hAB34);

    // Read-during-write to the same address.
    drive(1'b0, 7'd0, 1'b1, 7'd9, 16'h00FF, 2'b11);  step();
    drive(1'b1, 7'd9, 1'b1, 7'd9, 16'h1234, 2'b10);  step();
    check("rdw_bypass_a", obs_data[0], 32'h12FF);
    check("rdw_nobypass_b", obs_data[1], 32'h00FF);
    check("rdw_bypass_c", obs_data[2], 32'h12FF);
    drive(1'b1, 7'd9, 1'b0, 7'd0, 16'h0, 2'b00);     step();
    for (int k = 0; k < NInst; k++) check($sformatf("rdw_after%0d", k), obs_data[k], 32'h12FF);

    // Read register holds while the entry is rewritten underneath it.
    drive(1'b0, 7'd0, 1'b1, 7'd3, 16'h0042, 2'b11);  step();
    drive(1'b1, 7'd3, 1'b0, 7'd0, 16'h0, 2'b00);     step();
    for (int k = 0; k < NInst; k++) check($sformatf("hold_load%0d", k), obs_data[k], 32'h0042);
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 7'd3, 1'b1, 7'd3, 16'h7777, 2'b11);
      step();
      for (int k = 0; k < NInst; k++) begin
        check($sformatf("hold_data%0d", k), obs_data[k], 32'h0042);
        check($sformatf("hold_valid%0d", k), {31'b0, obs_valid[k]}, 32'h0);
      end
    end
    drive(1'b1, 7'd3, 1'b0, 7'd0, 16'h0, 2'b00);     step();
    for (int k = 0; k < NInst; k++) check($sformatf("hold_new%0d", k), obs_data[k], 32'h7777);

    // Address 120 is out of range only for the 100-entry instance.
    drive(1'b0, 7'd0, 1'b1, 7'd120, 16'hBEEF, 2'b11); step();
    drive(1'b1, 7'd120, 1'b0, 7'd0, 16'h0, 2'b00);    step();
    check("oor_data_c", obs_data[2], 32'h0);
    check("oor_valid_c", {31'b0, obs_valid[2]}, 32'h1);
    check("inrange_data_a", obs_data[0], 32'hBEEF);
    check("inrange_data_b", obs_data[1], 32'hBEEF);

    // Random traffic, with frequent same-address collisions.
    for (int n = 0; n < 2000; n++) begin
      logic [6:0] ra;
      ra = 7'($urandom_range(0, 127));
      drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? ra : 7'($urandom_range(0, 127)),
            16'($urandom), 2'($urandom_range(0, 3)));
      step();
    end

    // Reset in READY with a non-zero value sitting in the read register.
    drive(1'b0, 7'd0, 1'b1, 7'd1, 16'h5A5A, 2'b11);  step();
    drive(1'b1, 7'd1, 1'b0, 7'd0, 16'h0, 2'b00);     step();
    check("pre_reset_data_a", obs_data[0], 32'h5A5A);
    idle();
    async_reset("mid_ready");
    for (int n = 0; n < 130; n++) step();
    drive(1'b1, 7'd1, 1'b0, 7'd0, 16'h0, 2'b00);     step();
    for (int k = 0; k < NInst; k++) check($sformatf("reinit_zero%0d", k), obs_data[k], 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
